// File: rtl/afe_ro_buff_port_arb_pkg.sv
// afe_ro_buff_port_arb shared parameters
// and helpers for the readout buffer port scheduler.
package afe_ro_buff_port_arb_pkg;

  localparam int unsigned AFE_RO_RD_STARVE_MAX = 8;
  localparam int unsigned AFE_RO_NUM_REQ       = 4;
  localparam int unsigned AFE_RO_DATA_WIDTH    = 32;
  localparam int unsigned AFE_RO_BUFF_AWIDTH   = 10;

  // Pointer width for a requester count.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/afe_ro_buff_port_arb_if.sv
// Requester/SRAM bundle for the port arbiter.
// master = requesters + SRAM observer, slave = arbiter.
interface afe_ro_buff_port_arb_if #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int BUFF_AWIDTH = 10
);

  logic [NUM_REQ-1:0]             wr_valid_i;
  logic [NUM_REQ-1:0]             wr_ready_o;
  logic [NUM_REQ*BUFF_AWIDTH-1:0] wr_addr_i;
  logic [NUM_REQ*DATA_WIDTH-1:0]  wr_data_i;
  logic [NUM_REQ-1:0]             rd_valid_i;
  logic [NUM_REQ-1:0]             rd_ready_o;
  logic [NUM_REQ*BUFF_AWIDTH-1:0] rd_addr_i;
  logic [NUM_REQ-1:0]             rd_rvalid_o;
  logic                           buff_cen_o;
  logic                           buff_rwn_o;
  logic [BUFF_AWIDTH-1:0]         buff_addr_o;
  logic [DATA_WIDTH-1:0]          buff_wdata_o;

  modport master (
    output wr_valid_i, wr_addr_i, wr_data_i,
    output rd_valid_i, rd_addr_i,
    input  wr_ready_o, rd_ready_o, rd_rvalid_o,
    input  buff_cen_o, buff_rwn_o,
    input  buff_addr_o, buff_wdata_o
  );

  modport slave (
    input  wr_valid_i, wr_addr_i, wr_data_i,
    input  rd_valid_i, rd_addr_i,
    output wr_ready_o, rd_ready_o, rd_rvalid_o,
    output buff_cen_o, buff_rwn_o,
    output buff_addr_o, buff_wdata_o
  );

endinterface

// File: rtl/afe_ro_rr_sel.sv
// Round-robin picker: first set request at or
// after ptr_i, wrapping modulo NUM_REQ.
module afe_ro_rr_sel #(
  parameter int NUM_REQ = 4,
  parameter int PW      = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PW-1:0]      idx_o
);

  logic found;
  int   pos;

  // Scan from the pointer; first hit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = (int'(ptr_i) + k) % NUM_REQ;
      if (!found && req_i[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = PW'(pos);
      end
    end
  end

endmodule

// File: rtl/afe_ro_buff_port_arb.sv
// Single-port SRAM scheduler for the AFE
// readout buffer: write priority, bounded read starvation.
module afe_ro_buff_port_arb
  import afe_ro_buff_port_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int BUFF_AWIDTH   = 10,
  parameter int RD_STARVE_MAX = AFE_RO_RD_STARVE_MAX
) (
  input logic clk_i,
  input logic rst_ni,
  input logic test_mode_i,
  afe_ro_buff_port_arb_if.slave bus
);

  localparam int PW = ptr_w(NUM_REQ);
  localparam logic [7:0] STARVE_LAST =
    8'(RD_STARVE_MAX - 1);
  localparam logic [PW-1:0] PTR_LAST =
    PW'(NUM_REQ - 1);

  typedef enum logic {
    WR_PRIO  = 1'b0,
    RD_FORCE = 1'b1
  } mode_e;

  mode_e              mode_q, mode_d;
  logic [7:0]         starve_q, starve_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;

  logic [NUM_REQ-1:0] wr_gnt, rd_gnt;
  logic [PW-1:0]      wr_idx, rd_idx;
  logic               any_wr, any_rd;
  logic               wr_sel, rd_sel;

  logic [BUFF_AWIDTH-1:0] wa [NUM_REQ];
  logic [DATA_WIDTH-1:0]  wd [NUM_REQ];
  logic [BUFF_AWIDTH-1:0] ra [NUM_REQ];

  logic unused_test_mode;
  assign unused_test_mode = test_mode_i;

  afe_ro_rr_sel #(
    .NUM_REQ(NUM_REQ),
    .PW     (PW)
  ) u_wr_sel (
    .req_i(bus.wr_valid_i),
    .ptr_i(wr_ptr_q),
    .gnt_o(wr_gnt),
    .idx_o(wr_idx)
  );

  afe_ro_rr_sel #(
    .NUM_REQ(NUM_REQ),
    .PW     (PW)
  ) u_rd_sel (
    .req_i(bus.rd_valid_i),
    .ptr_i(rd_ptr_q),
    .gnt_o(rd_gnt),
    .idx_o(rd_idx)
  );

  // Unpack flat request buses into per-port words.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      wa[i] = bus.wr_addr_i[i*BUFF_AWIDTH +: BUFF_AWIDTH];
      wd[i] = bus.wr_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      ra[i] = bus.rd_addr_i[i*BUFF_AWIDTH +: BUFF_AWIDTH];
    end
  end

  assign any_wr = |bus.wr_valid_i;
  assign any_rd = |bus.rd_valid_i;
  assign rd_sel = any_rd &&
                  ((mode_q == RD_FORCE) || !any_wr);
  assign wr_sel = any_wr && !rd_sel;

  assign bus.wr_ready_o  = wr_sel ? wr_gnt : '0;
  assign bus.rd_ready_o  = rd_sel ? rd_gnt : '0;
  assign bus.rd_rvalid_o = rvalid_q;

  // Drive the SRAM port from the single winner.
  always_comb begin
    bus.buff_cen_o   = 1'b1;
    bus.buff_rwn_o   = 1'b1;
    bus.buff_addr_o  = '0;
    bus.buff_wdata_o = '0;
    unique case (1'b1)
      wr_sel: begin
        bus.buff_cen_o   = 1'b0;
        bus.buff_rwn_o   = 1'b0;
        bus.buff_addr_o  = wa[wr_idx];
        bus.buff_wdata_o = wd[wr_idx];
      end
      rd_sel: begin
        bus.buff_cen_o  = 1'b0;
        bus.buff_addr_o = ra[rd_idx];
      end
      default: ;
    endcase
  end

  // Next state: pointers, starvation, mode, rvalid.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    starve_d = '0;
    mode_d   = mode_q;
    rvalid_d = bus.rd_ready_o;
    if (wr_sel)
      wr_ptr_d = (wr_idx == PTR_LAST) ? '0 : wr_idx + 1'b1;
    if (rd_sel)
      rd_ptr_d = (rd_idx == PTR_LAST) ? '0 : rd_idx + 1'b1;
    if (any_rd && !rd_sel)
      starve_d = starve_q + 8'd1;
    unique case (mode_q)
      WR_PRIO:
        if (any_rd && !rd_sel && starve_q == STARVE_LAST)
          mode_d = RD_FORCE;
      RD_FORCE: mode_d = WR_PRIO;
      default:  mode_d = WR_PRIO;
    endcase
  end

  // State registers; reset kills any in-flight read return.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q   <= WR_PRIO;
      starve_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rvalid_q <= '0;
    end else begin
      mode_q   <= mode_d;
      starve_q <= starve_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rvalid_q <= rvalid_d;
    end
  end

endmodule

// File: tb/tb_afe_ro_buff_port_arb.sv
// Bench for afe_ro_buff_port_arb: directed
// scenarios plus random traffic against a reference model.
module tb_afe_ro_buff_port_arb;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SM = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  afe_ro_buff_port_arb_if #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .BUFF_AWIDTH(AW)
  ) bus ();

  afe_ro_buff_port_arb_if #(
    .NUM_REQ(3), .DATA_WIDTH(DW), .BUFF_AWIDTH(AW)
  ) bus3 ();

  afe_ro_buff_port_arb #(
    .NUM_REQ(N), .DATA_WIDTH(DW),
    .BUFF_AWIDTH(AW), .RD_STARVE_MAX(SM)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .test_mode_i(1'b0), .bus(bus)
  );

  afe_ro_buff_port_arb #(
    .NUM_REQ(3), .DATA_WIDTH(DW),
    .BUFF_AWIDTH(AW), .RD_STARVE_MAX(SM)
  ) dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .test_mode_i(1'b0), .bus(bus3)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [AW-1:0] wa [N];
  logic [DW-1:0] wd [N];
  logic [AW-1:0] ra [N];

  int        m_wptr, m_rptr, m_starve;
  bit        m_force;
  logic [N-1:0] last_ew, last_er, obs_rd;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic int rr(input logic [N-1:0] v,
                            input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_wptr = 0; m_rptr = 0; m_starve = 0;
    m_force = 1'b0;
  endtask

  // One cycle: drive, check comb outputs, clock, check rvalid.
  task automatic tick(input logic [N-1:0] wv,
                      input logic [N-1:0] rv);
    bit any_w, any_r, rdt, wrt;
    int wi, ri;
    logic [N-1:0] ew, er;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] edata;
    bus.wr_valid_i = wv;
    bus.rd_valid_i = rv;
    for (int i = 0; i < N; i++) begin
      bus.wr_addr_i[i*AW +: AW] = wa[i];
      bus.wr_data_i[i*DW +: DW] = wd[i];
      bus.rd_addr_i[i*AW +: AW] = ra[i];
    end
    #1;
    any_w = |wv;
    any_r = |rv;
    rdt = any_r && (m_force || !any_w);
    wrt = any_w && !rdt;
    ew = '0; er = '0; eaddr = '0; edata = '0;
    wi = rr(wv, m_wptr);
    ri = rr(rv, m_rptr);
    if (wrt) begin
      ew[wi] = 1'b1; eaddr = wa[wi]; edata = wd[wi];
    end
    if (rdt) begin
      er[ri] = 1'b1; eaddr = ra[ri];
    end
    chk("wr_ready", 64'(bus.wr_ready_o), 64'(ew));
    chk("rd_ready", 64'(bus.rd_ready_o), 64'(er));
    chk("cen", 64'(bus.buff_cen_o), 64'(!(wrt || rdt)));
    chk("rwn", 64'(bus.buff_rwn_o), 64'(!wrt));
    chk("addr", 64'(bus.buff_addr_o), 64'(eaddr));
    chk("wdata", 64'(bus.buff_wdata_o), 64'(edata));
    chk("onehot",
        64'($onehot0({bus.wr_ready_o, bus.rd_ready_o})),
        64'd1);
    obs_rd = bus.rd_ready_o;
    @(posedge clk);
    if (wrt) m_wptr = (wi + 1) % N;
    if (rdt) m_rptr = (ri + 1) % N;
    m_force = any_r && !rdt && (m_starve == SM - 1);
    m_starve = (any_r && !rdt) ? m_starve + 1 : 0;
    last_ew = ew;
    last_er = er;
    #1;
    chk("rvalid", 64'(bus.rd_rvalid_o), 64'(er));
  endtask

  int nreads;
  logic [N-1:0] pw, pr;

  initial begin
    bus.wr_valid_i = '0; bus.rd_valid_i = '0;
    bus.wr_addr_i = '0; bus.wr_data_i = '0;
    bus.rd_addr_i = '0;
    bus3.wr_valid_i = '0; bus3.rd_valid_i = '0;
    bus3.wr_addr_i = '0; bus3.wr_data_i = '0;
    bus3.rd_addr_i = '0;
    for (int i = 0; i < N; i++) begin
      wa[i] = AW'(16 + i); wd[i] = DW'(32'hA000 + i);
      ra[i] = AW'(64 + i);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset.
    chk("rst_rvalid", 64'(bus.rd_rvalid_o), 64'd0);
    tick('0, '0);

    // Single write from requester 2.
    wa[2] = AW'(5); wd[2] = 32'hDEADBEEF;
    tick(4'b0100, '0);
    chk("single_wr", 64'(last_ew), 64'h4);
    // Pointer now 3: all writers -> 3,0,1,2.
    repeat (4) tick(4'b1111, '0);
    chk("wr_wrap", 64'(last_ew), 64'h4);
    repeat (4) tick('0, 4'b1111);
    chk("rd_last", 64'(last_er), 64'h8);

    // Writer 1 saturating, reader 0 waiting.
    nreads = 0;
    for (int c = 0; c < 27; c++) begin
      tick(4'b0010, 4'b0001);
      if (obs_rd != '0) nreads++;
    end
    chk("starve_reads", 64'(nreads), 64'd3);

    // Write and read pending from idle.
    tick(4'b0001, 4'b0010);
    chk("wr_first", 64'(last_ew), 64'h1);
    tick('0, 4'b0010);
    chk("rd_next", 64'(last_er), 64'h2);

    // Reset in the middle of a read return.
    bus.wr_valid_i = '0;
    bus.rd_valid_i = 4'b0010;
    @(posedge clk);
    #1 chk("pre_rst_rv", 64'(bus.rd_rvalid_o), 64'h2);
    #3 rst_n = 1'b0;
    #1 chk("rst_kill_rv", 64'(bus.rd_rvalid_o), 64'h0);
    bus.rd_valid_i = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    chk("rst_cen", 64'(bus.buff_cen_o), 64'd1);
    tick('0, '0);
    tick(4'b1111, '0);
    chk("rst_wptr", 64'(last_ew), 64'h1);
    tick('0, 4'b1111);
    chk("rst_rptr", 64'(last_er), 64'h1);

    // Random traffic, requests held until granted.
    pw = '0; pr = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pw[i] && ($urandom_range(0, 2) == 0)) begin
          pw[i] = 1'b1;
          wa[i] = AW'($urandom); wd[i] = $urandom;
        end
        if (!pr[i] && ($urandom_range(0, 3) == 0)) begin
          pr[i] = 1'b1;
          ra[i] = AW'($urandom);
        end
      end
      tick(pw, pr);
      pw = pw & ~last_ew;
      pr = pr & ~last_er;
    end
    tick('0, '0);

    // Three-requester wrap on the second instance.
    bus3.wr_valid_i = 3'b010;
    #1 chk("n3_g1", 64'(bus3.wr_ready_o), 64'h2);
    @(posedge clk); #1;
    bus3.wr_valid_i = 3'b011;
    #1 chk("n3_g0", 64'(bus3.wr_ready_o), 64'h1);
    @(posedge clk); #1;
    bus3.wr_valid_i = 3'b010;
    #1 chk("n3_g1b", 64'(bus3.wr_ready_o), 64'h2);
    @(posedge clk); #1;
    bus3.wr_valid_i = 3'b111;
    #1 chk("n3_ptr2", 64'(bus3.wr_ready_o), 64'h4);
    @(posedge clk); #1;
    bus3.wr_valid_i = '0;
    #1 chk("n3_idle", 64'(bus3.buff_cen_o), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end

endmodule
